word_serdes: RTL and testbench

WORD_SERDES -- requirements
Module: word_serdes

---
 rtl/word_serdes.sv | 160 ++++++++++++++++
 tb/tb_word_serdes.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serdes.sv
// Word <-> lane serializer/deserializer pair sharing one clock, running independently.
// Latency: first lane beat 1 cycle after load handshake; word_valid 1 cycle after the last input lane.
// Backpressure: serializer stalls on lane_ready=0 (lane_out held); deserializer has none (in_valid only).
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   abort              synchronous clear of serializer and deserializer progress
//   load_word/_valid   word offered for serialization; load_ready accepts it
//   lane_out/_valid    serialized beat, lane_last marks beat N-1; lane_ready from downstream
//   in_lane/in_valid   deserializer input lanes
//   word_out           last completed word; word_valid pulses for one cycle on completion
module word_serdes #(
    parameter int WORD_W    = 32,
    parameter int LANE_W    = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic [WORD_W-1:0] load_word,
    input  logic              load_valid,
    output logic              load_ready,
    output logic [LANE_W-1:0] lane_out,
    output logic              lane_valid,
    output logic              lane_last,
    input  logic              lane_ready,
    input  logic [LANE_W-1:0] in_lane,
    input  logic              in_valid,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid
);

    localparam int N     = WORD_W / LANE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // A word viewed as N lanes; lane k is bits k*LANE_W +: LANE_W.
    typedef logic [N-1:0][LANE_W-1:0] lanes_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    // Maps a beat number to the lane it carries; the same mapping is used
    // by both directions so a serializer feeding a deserializer round-trips.
    function automatic logic [IDX_W-1:0] lane_pos(input logic [IDX_W-1:0] beat);
        logic [IDX_W-1:0] pos;
        if (MSB_FIRST) begin
            pos = LAST_IDX - beat;
        end else begin
            pos = beat;
        end
        return pos;
    endfunction

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    ser_state_t        state_q;
    lanes_t            shreg_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LANE_W-1:0] lane_out_q;
    logic              lane_valid_q;

    lanes_t            load_lanes;
    logic              is_last;
    logic              xfer;
    logic              load_fire;

    assign load_lanes = load_word;
    assign is_last    = lane_valid_q && (idx_q == LAST_IDX);
    assign xfer       = lane_valid_q && lane_ready;

    // Accepting in SHIFT only while the final beat leaves lets a new word
    // follow the previous one with no idle cycle between them.
    assign load_ready = (state_q == S_IDLE) || (is_last && lane_ready);
    assign load_fire  = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            idx_q        <= '0;
            lane_out_q   <= '0;
            lane_valid_q <= 1'b0;
        end else if (abort) begin
            // lane_out_q is left alone: idle lane_out keeps its last value.
            state_q      <= S_IDLE;
            idx_q        <= '0;
            lane_valid_q <= 1'b0;
        end else if (load_fire) begin
            state_q      <= S_SHIFT;
            shreg_q      <= load_lanes;
            idx_q        <= '0;
            lane_out_q   <= load_lanes[lane_pos('0)];
            lane_valid_q <= 1'b1;
        end else if (xfer) begin
            if (idx_q == LAST_IDX) begin
                state_q      <= S_IDLE;
                idx_q        <= '0;
                lane_valid_q <= 1'b0;
            end else begin
                idx_q      <= idx_q + IDX_ONE;
                lane_out_q <= shreg_q[lane_pos(idx_q + IDX_ONE)];
            end
        end
    end

    assign lane_out   = lane_out_q;
    assign lane_valid = lane_valid_q;
    assign lane_last  = is_last;

    // ------------------------------------------------------------------
    // Deserializer
    // ------------------------------------------------------------------
    // Lanes gather in asm_q so word_out only changes when a word completes.
    lanes_t            asm_q;
    lanes_t            asm_next;
    logic [IDX_W-1:0]  cnt_q;
    logic [WORD_W-1:0] word_out_q;
    logic              word_valid_q;

    always_comb begin
        asm_next = asm_q;
        if (in_valid) begin
            asm_next[lane_pos(cnt_q)] = in_lane;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q        <= '0;
            cnt_q        <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
        end else if (abort) begin
            cnt_q        <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (in_valid) begin
                asm_q <= asm_next;
                if (cnt_q == LAST_IDX) begin
                    cnt_q        <= '0;
                    word_out_q   <= asm_next;
                    word_valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + IDX_ONE;
                end
            end
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_word_serdes.sv
module tb_word_serdes;

    logic clk;
    logic rst_n;

    // DUT 0: LSB-first
    logic        abort0, load_valid0, lane_ready0, in_valid0;
    logic [31:0] load_word0;
    logic [7:0]  in_lane0;
    logic        load_ready0, lane_valid0, lane_last0, word_valid0;
    logic [7:0]  lane_out0;
    logic [31:0] word_out0;

    // DUT 1: MSB-first
    logic        abort1, load_valid1, lane_ready1, in_valid1;
    logic [31:0] load_word1;
    logic [7:0]  in_lane1;
    logic        load_ready1, lane_valid1, lane_last1, word_valid1;
    logic [7:0]  lane_out1;
    logic [31:0] word_out1;

    word_serdes #(.WORD_W(32), .LANE_W(8), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .abort(abort0),
        .load_word(load_word0), .load_valid(load_valid0), .load_ready(load_ready0),
        .lane_out(lane_out0), .lane_valid(lane_valid0), .lane_last(lane_last0),
        .lane_ready(lane_ready0), .in_lane(in_lane0), .in_valid(in_valid0),
        .word_out(word_out0), .word_valid(word_valid0)
    );

    word_serdes #(.WORD_W(32), .LANE_W(8), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .abort(abort1),
        .load_word(load_word1), .load_valid(load_valid1), .load_ready(load_ready1),
        .lane_out(lane_out1), .lane_valid(lane_valid1), .lane_last(lane_last1),
        .lane_ready(lane_ready1), .in_lane(in_lane1), .in_valid(in_valid1),
        .word_out(word_out1), .word_valid(word_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected beats are {lane_last, lane_out}.
    logic [8:0]  sq0[$];
    logic [8:0]  sq1[$];
    logic [31:0] wq0[$];
    logic [31:0] wq1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_lsb(input logic [31:0] w);
        for (int k = 0; k < 4; k++) sq0.push_back({(k == 3), w[k*8 +: 8]});
    endtask

    task automatic push_msb(input logic [31:0] w);
        for (int k = 0; k < 4; k++) sq1.push_back({(k == 3), w[(3-k)*8 +: 8]});
    endtask

    // ---------------- monitors ----------------
    logic       stall0, stall1;
    logic [7:0] held0, held1;
    logic [8:0] eb0, eb1;
    logic [31:0] ew0, ew1;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall0 = 1'b0;
        end else begin
            if (stall0 && lane_valid0) chk("hold0", {24'd0, lane_out0}, {24'd0, held0});
            stall0 = lane_valid0 && !lane_ready0;
            held0  = lane_out0;
            if (lane_valid0 && lane_ready0) begin
                if (sq0.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL beat0: got unexpected beat %h, expected none", lane_out0);
                end else begin
                    eb0 = sq0.pop_front();
                    chk("beat0", {23'd0, lane_last0, lane_out0}, {23'd0, eb0});
                end
            end
            if (word_valid0) begin
                if (wq0.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL word0: got unexpected word %h, expected none", word_out0);
                end else begin
                    ew0 = wq0.pop_front();
                    chk("word0", word_out0, ew0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall1 = 1'b0;
        end else begin
            if (stall1 && lane_valid1) chk("hold1", {24'd0, lane_out1}, {24'd0, held1});
            stall1 = lane_valid1 && !lane_ready1;
            held1  = lane_out1;
            if (lane_valid1 && lane_ready1) begin
                if (sq1.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL beat1: got unexpected beat %h, expected none", lane_out1);
                end else begin
                    eb1 = sq1.pop_front();
                    chk("beat1", {23'd0, lane_last1, lane_out1}, {23'd0, eb1});
                end
            end
            if (word_valid1) begin
                if (wq1.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL word1: got unexpected word %h, expected none", word_out1);
                end else begin
                    ew1 = wq1.pop_front();
                    chk("word1", word_out1, ew1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bit hs, got_hs;
    logic [7:0] dlanes [4];

    initial begin
        rst_n = 1'b1;
        abort0 = 0; load_valid0 = 0; lane_ready0 = 0; in_valid0 = 0; load_word0 = '0; in_lane0 = '0;
        abort1 = 0; load_valid1 = 0; lane_ready1 = 0; in_valid1 = 0; load_word1 = '0; in_lane1 = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_load_ready", {31'd0, load_ready0}, 32'd1);
        chk("rst_lane_valid", {31'd0, lane_valid0}, 32'd0);
        chk("rst_lane_last",  {31'd0, lane_last0}, 32'd0);
        chk("rst_lane_out",   {24'd0, lane_out0}, 32'd0);
        chk("rst_word_out",   word_out0, 32'd0);
        chk("rst_word_valid", {31'd0, word_valid0}, 32'd0);
        tick; tick;
        rst_n = 1'b1;

        // Plain word, lane_ready held high
        push_lsb(32'hDEADBEEF);
        load_word0 = 32'hDEADBEEF; load_valid0 = 1; lane_ready0 = 1;
        tick;
        load_valid0 = 0;
        tick; tick; tick;
        chk("last_beat_lane_last",  {31'd0, lane_last0}, 32'd1);
        chk("last_beat_load_ready", {31'd0, load_ready0}, 32'd1);
        tick;
        chk("idle_lane_valid", {31'd0, lane_valid0}, 32'd0);
        chk("idle_lane_last",  {31'd0, lane_last0}, 32'd0);
        chk("idle_lane_out_held", {24'd0, lane_out0}, 32'h0000_00DE);

        // Same word under a stall pattern
        push_lsb(32'hDEADBEEF);
        load_valid0 = 1;
        tick;
        load_valid0 = 0;
        for (int i = 0; i < 7; i++) begin
            lane_ready0 = pat[i];
            tick;
        end
        chk("stall_done_idle", {31'd0, lane_valid0}, 32'd0);

        // Back-to-back words with no bubble
        lane_ready0 = 1;
        push_lsb(32'h11223344);
        push_lsb(32'hA5A50F0F);
        load_word0 = 32'h11223344; load_valid0 = 1;
        tick;
        load_word0 = 32'hA5A50F0F;
        got_hs = 0;
        for (int c = 0; c < 8; c++) begin
            chk("b2b_no_gap", {31'd0, lane_valid0}, 32'd1);
            hs = load_valid0 && load_ready0;
            tick;
            if (hs) begin
                got_hs = 1;
                load_valid0 = 0;
            end
        end
        chk("b2b_second_taken", {31'd0, got_hs}, 32'd1);
        chk("b2b_done_idle", {31'd0, lane_valid0}, 32'd0);

        // Deserializer: plain word, then partial + abort + full word
        wq0.push_back(32'hDDCCBBAA);
        dlanes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) begin
            in_valid0 = 1; in_lane0 = dlanes[i];
            tick;
        end
        in_valid0 = 0;
        tick;
        wq0.push_back(32'h66554433);
        in_valid0 = 1; in_lane0 = 8'h11; tick;
        in_lane0 = 8'h22; tick;
        chk("partial_no_change", word_out0, 32'hDDCCBBAA);
        abort0 = 1; in_lane0 = 8'h77;
        tick;
        abort0 = 0;
        chk("abort_word_kept", word_out0, 32'hDDCCBBAA);
        chk("abort_no_pulse", {31'd0, word_valid0}, 32'd0);
        dlanes = '{8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 4; i++) begin
            in_lane0 = dlanes[i];
            tick;
        end
        in_valid0 = 0;
        tick;
        chk("pulse_one_cycle", {31'd0, word_valid0}, 32'd0);
        chk("word_out_holds", word_out0, 32'h66554433);

        // Abort on beat 2 of a word
        sq0.push_back({1'b0, 8'hEF});
        sq0.push_back({1'b0, 8'hBE});
        load_word0 = 32'hDEADBEEF; load_valid0 = 1; lane_ready0 = 1;
        tick;
        load_valid0 = 0;
        tick;
        tick;
        chk("abort_beat2_shown", {24'd0, lane_out0}, 32'h0000_00AD);
        abort0 = 1; lane_ready0 = 0; load_valid0 = 1; load_word0 = 32'h12345678;
        tick;
        chk("abort_lane_valid", {31'd0, lane_valid0}, 32'd0);
        chk("abort_lane_last",  {31'd0, lane_last0}, 32'd0);
        chk("abort_load_ready", {31'd0, load_ready0}, 32'd1);
        tick;
        chk("abort_load_ignored", {31'd0, lane_valid0}, 32'd0);
        abort0 = 0; load_valid0 = 0;
        tick;
        push_lsb(32'h0A0B0C0D);
        load_word0 = 32'h0A0B0C0D; load_valid0 = 1; lane_ready0 = 1;
        tick;
        load_valid0 = 0;
        repeat (5) tick;

        // MSB-first instance, both directions at once
        push_msb(32'hDEADBEEF);
        wq1.push_back(32'h12345678);
        load_word1 = 32'hDEADBEEF; load_valid1 = 1; lane_ready1 = 1;
        dlanes = '{8'h12, 8'h34, 8'h56, 8'h78};
        for (int i = 0; i < 4; i++) begin
            in_valid1 = 1; in_lane1 = dlanes[i];
            tick;
            load_valid1 = 0;
        end
        in_valid1 = 0;
        repeat (3) tick;

        // Reset asserted mid-word
        sq0.push_back({1'b0, 8'hEF});
        load_word0 = 32'hDEADBEEF; load_valid0 = 1; lane_ready0 = 1;
        in_valid0 = 1; in_lane0 = 8'h9A;
        tick;
        load_valid0 = 0; in_valid0 = 0;
        tick;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_lane_valid", {31'd0, lane_valid0}, 32'd0);
        chk("mid_rst_lane_last",  {31'd0, lane_last0}, 32'd0);
        chk("mid_rst_lane_out",   {24'd0, lane_out0}, 32'd0);
        chk("mid_rst_load_ready", {31'd0, load_ready0}, 32'd1);
        chk("mid_rst_word_out",   word_out0, 32'd0);
        chk("mid_rst_word_valid", {31'd0, word_valid0}, 32'd0);
        tick; tick;
        rst_n = 1'b1;

        // Fresh word and fresh lane 0 after release, run concurrently
        push_lsb(32'h55667788);
        wq0.push_back(32'h04030201);
        load_word0 = 32'h55667788; load_valid0 = 1; lane_ready0 = 1;
        dlanes = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 4; i++) begin
            in_valid0 = 1; in_lane0 = dlanes[i];
            tick;
            load_valid0 = 0;
        end
        in_valid0 = 0;
        repeat (4) tick;

        chk("beats0_drained", sq0.size(), 32'd0);
        chk("words0_drained", wq0.size(), 32'd0);
        chk("beats1_drained", sq1.size(), 32'd0);
        chk("words1_drained", wq1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
